// File: rtl/loop_sdram_master_if.sv
// Avalon-MM style SDRAM slave bus (sdram_* signals) shared by the looper master and the controller.
interface loop_sdram_master_if #(
  parameter int ADDR_W = 25
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable_n;
  logic              chipselect;
  logic [31:0]       writedata;
  logic              read_n;
  logic              write_n;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, byteenable_n, chipselect, writedata, read_n, write_n,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable_n, chipselect, writedata, read_n, write_n,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/loop_sdram_master.sv
// Looper buffer master: per audio frame tick, read the loop word for playback, optionally write
// the record sample (replace or saturating overdub), then advance the wrapping loop position.
module loop_sdram_master #(
  parameter int ADDR_W     = 25,
  parameter int RD_TIMEOUT = 255,
  parameter bit MIX_EN     = 1'b1
) (
  input  logic                clk_clk,
  input  logic                reset_n_reset_n,
  input  logic                sample_tick,
  input  logic                rec_en,
  input  logic                play_en,
  input  logic [31:0]         rec_data,
  input  logic [ADDR_W-1:0]   loop_base,
  input  logic [ADDR_W-1:0]   loop_len,
  input  logic                clear,
  output logic [31:0]         play_data,
  output logic                play_valid,
  output logic [ADDR_W-1:0]   pos,
  output logic                overrun,
  output logic                rd_timeout,
  loop_sdram_master_if.master sdram
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_ADV     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       play_data_q, play_data_d;
  logic              play_valid_q, play_valid_d;
  logic              overrun_q, overrun_d;
  logic              rd_to_q, rd_to_d;
  logic              stale_q, stale_d;
  logic              clear_seen_q, clear_seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rec_lat_q, rec_lat_d;
  logic              play_lat_q, play_lat_d;
  logic [31:0]       rec_data_lat_q, rec_data_lat_d;
  logic              cs_q, cs_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic [ADDR_W:0]   pos_inc;

  // Signed 16-bit add clamped to [-32768, 32767].
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) begin
      return s[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      return s[15:0];
    end
  endfunction

  assign pos_inc = {1'b0, pos_q} + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state, position, capture and bus-strobe computation.
  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    addr_d         = addr_q;
    play_data_d    = play_data_q;
    play_valid_d   = 1'b0;
    cnt_d          = cnt_q;
    rec_lat_d      = rec_lat_q;
    play_lat_d     = play_lat_q;
    rec_data_lat_d = rec_data_lat_q;
    // Sticky flags: clear wins over old state, a new event in the same cycle wins over clear.
    overrun_d      = (overrun_q && !clear) || (sample_tick && (state_q != S_IDLE));
    rd_to_d        = rd_to_q && !clear;
    stale_d        = stale_q && !sdram.readdatavalid;
    clear_seen_d   = clear_seen_q || (clear && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          pos_d = {ADDR_W{1'b0}};
        end else begin
          pos_d = pos_q;
        end
        if (sample_tick) begin
          rec_lat_d      = rec_en;
          play_lat_d     = play_en;
          rec_data_lat_d = rec_data;
          clear_seen_d   = 1'b0;
          addr_d         = loop_base + pos_d;
          cnt_d          = {CNT_W{1'b0}};
          if (play_en) begin
            state_d = S_RD_REQ;
          end else if (rec_en) begin
            state_d = S_WR_REQ;
          end else begin
            state_d = S_ADV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (!sdram.waitrequest) begin
          state_d = S_RD_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (sdram.readdatavalid && !stale_q) begin
          play_data_d  = sdram.readdata;
          play_valid_d = 1'b1;
          state_d      = rec_lat_q ? S_WR_REQ : S_ADV;
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the read; its data may still arrive later and must be swallowed.
          play_data_d  = 32'h0000_0000;
          play_valid_d = 1'b1;
          rd_to_d      = 1'b1;
          stale_d      = 1'b1;
          state_d      = rec_lat_q ? S_WR_REQ : S_ADV;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = S_RD_WAIT;
        end
      end
      S_WR_REQ: begin
        if (!sdram.waitrequest) begin
          state_d = S_ADV;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_ADV: begin
        if (clear_seen_q || clear || (loop_len == {ADDR_W{1'b0}}) || (pos_inc >= {1'b0, loop_len})) begin
          pos_d = {ADDR_W{1'b0}};
        end else begin
          pos_d = pos_inc[ADDR_W-1:0];
        end
        clear_seen_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d == S_WR_REQ) && (state_q != S_WR_REQ)) begin
      if (MIX_EN && play_lat_d) begin
        wdata_d = {sat_add16(rec_data_lat_d[31:16], play_data_d[31:16]),
                   sat_add16(rec_data_lat_d[15:0],  play_data_d[15:0])};
      end else begin
        wdata_d = rec_data_lat_d;
      end
    end else begin
      wdata_d = wdata_q;
    end

    cs_d   = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    rd_n_d = (state_d != S_RD_REQ);
    wr_n_d = (state_d != S_WR_REQ);
    be_n_d = cs_d ? 4'h0 : 4'hF;
  end

  // State and output registers; reset leaves the bus idle with no read pending.
  always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
    if (!reset_n_reset_n) begin
      state_q        <= S_IDLE;
      pos_q          <= {ADDR_W{1'b0}};
      addr_q         <= {ADDR_W{1'b0}};
      wdata_q        <= 32'h0000_0000;
      play_data_q    <= 32'h0000_0000;
      play_valid_q   <= 1'b0;
      overrun_q      <= 1'b0;
      rd_to_q        <= 1'b0;
      stale_q        <= 1'b0;
      clear_seen_q   <= 1'b0;
      cnt_q          <= {CNT_W{1'b0}};
      rec_lat_q      <= 1'b0;
      play_lat_q     <= 1'b0;
      rec_data_lat_q <= 32'h0000_0000;
      cs_q           <= 1'b0;
      rd_n_q         <= 1'b1;
      wr_n_q         <= 1'b1;
      be_n_q         <= 4'hF;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      play_data_q    <= play_data_d;
      play_valid_q   <= play_valid_d;
      overrun_q      <= overrun_d;
      rd_to_q        <= rd_to_d;
      stale_q        <= stale_d;
      clear_seen_q   <= clear_seen_d;
      cnt_q          <= cnt_d;
      rec_lat_q      <= rec_lat_d;
      play_lat_q     <= play_lat_d;
      rec_data_lat_q <= rec_data_lat_d;
      cs_q           <= cs_d;
      rd_n_q         <= rd_n_d;
      wr_n_q         <= wr_n_d;
      be_n_q         <= be_n_d;
    end
  end

  assign play_data          = play_data_q;
  assign play_valid         = play_valid_q;
  assign pos                = pos_q;
  assign overrun            = overrun_q;
  assign rd_timeout         = rd_to_q;
  assign sdram.address      = addr_q;
  assign sdram.byteenable_n = be_n_q;
  assign sdram.chipselect   = cs_q;
  assign sdram.writedata    = wdata_q;
  assign sdram.read_n       = rd_n_q;
  assign sdram.write_n      = wr_n_q;

endmodule

// File: tb/tb_loop_sdram_master.sv
// Self-checking bench for loop_sdram_master: vector table plus hand-written corner sequences,
// with a scoreboard of expected reads, writes and playback words.
module tb_loop_sdram_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0, rec_en = 1'b0, play_en = 1'b0, clear = 1'b0;
  logic [31:0] rec_data = 32'h0;
  logic [24:0] loop_base = 25'h100, loop_len = 25'd4;
  logic [31:0] play_data;
  logic        play_valid, overrun, rd_timeout;
  logic [24:0] pos;

  int checks = 0;
  int failures = 0;

  // slave model controls
  int          wait_n = 0;
  int          wcnt;
  bit          drop_rd = 1'b0;
  bit          force_en = 1'b0;
  logic [31:0] force_val = 32'h0;
  logic        inj_v = 1'b0;
  logic [31:0] inj_data = 32'h0;
  logic        rv_pend;
  logic [31:0] rv_data;
  int          rd_acc = 0, wr_acc = 0;

  logic [24:0] exp_rd_q[$];
  logic [31:0] exp_play_q[$];
  logic [56:0] exp_wr_q[$];

  logic        hold_v;
  logic [63:0] hold_sig;

  loop_sdram_master_if #(.ADDR_W(25)) sbus ();

  loop_sdram_master #(.ADDR_W(25), .RD_TIMEOUT(8), .MIX_EN(1'b1)) dut (
    .clk_clk(clk), .reset_n_reset_n(rst_n), .sample_tick(sample_tick), .rec_en(rec_en),
    .play_en(play_en), .rec_data(rec_data), .loop_base(loop_base), .loop_len(loop_len),
    .clear(clear), .play_data(play_data), .play_valid(play_valid), .pos(pos),
    .overrun(overrun), .rd_timeout(rd_timeout), .sdram(sbus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  assign sbus.waitrequest   = sbus.chipselect && (wcnt < wait_n);
  assign sbus.readdatavalid = rv_pend | inj_v;
  assign sbus.readdata      = inj_v ? inj_data : rv_data;

  // SDRAM slave model: programmable wait states, read data one cycle after acceptance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0; rv_pend <= 1'b0; rv_data <= 32'h0;
    end else begin
      if (sbus.chipselect && sbus.waitrequest) wcnt <= wcnt + 1;
      else wcnt <= 0;
      rv_pend <= 1'b0;
      if (sbus.chipselect && !sbus.read_n && !sbus.waitrequest) begin
        rv_pend <= !drop_rd;
        rv_data <= force_en ? force_val : (32'hA0 + 32'(sbus.address));
      end
    end
  end

  // Scoreboard and bus-protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v)
        chk("hold_stable", {sbus.address, sbus.writedata, sbus.chipselect, sbus.read_n, sbus.write_n, sbus.byteenable_n}, hold_sig);
      hold_v   <= sbus.chipselect && sbus.waitrequest;
      hold_sig <= {sbus.address, sbus.writedata, sbus.chipselect, sbus.read_n, sbus.write_n, sbus.byteenable_n};
      if (!sbus.read_n || !sbus.write_n)
        chk("strobe_cs_excl", {sbus.chipselect, sbus.read_n ^ sbus.write_n}, 2'b11);
      if (sbus.chipselect && !sbus.read_n && !sbus.waitrequest) begin
        rd_acc <= rd_acc + 1;
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
        else chk("rd_addr", sbus.address, exp_rd_q.pop_front());
      end
      if (sbus.chipselect && !sbus.write_n && !sbus.waitrequest) begin
        wr_acc <= wr_acc + 1;
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
        else chk("wr_addr_data", {sbus.address, sbus.writedata}, exp_wr_q.pop_front());
      end
      if (play_valid) begin
        if (exp_play_q.size() == 0) chk("play_unexpected", 64'd1, 64'd0);
        else chk("play_data", play_data, exp_play_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit p, input bit r, input logic [31:0] d);
    @(posedge clk); #1;
    sample_tick = 1'b1; play_en = p; rec_en = r; rec_data = d;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  typedef struct {
    bit          play;
    bit          rec;
    bit          fen;
    logic [31:0] fval;
    logic [31:0] rdat;
    logic [24:0] addr;
    logic [31:0] exp_play;
    logic [31:0] exp_wdata;
    logic [24:0] exp_pos;
  } vec_t;

  vec_t vecs[11];
  int   rd0, wr0;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 25'h100, 32'h1A0, 32'h0, 25'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 25'h101, 32'h1A1, 32'h0, 25'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 25'h102, 32'h1A2, 32'h0, 25'd3};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 25'h103, 32'h1A3, 32'h0, 25'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 25'h100, 32'h1A0, 32'h0, 25'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 25'h101, 32'h1A1, 32'h0, 25'd2};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h7000_8000, 32'h2000_F000, 25'h102, 32'h7000_8000, 32'h7FFF_8000, 25'd3};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 25'h103, 32'h0, 32'h1234_5678, 25'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0001_0002, 25'h100, 32'h1A0, 32'h0001_01A2, 25'd1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 25'h101, 32'h8000_0001, 32'h8000_0000, 25'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 25'h102, 32'h0, 32'h0, 25'd3};

    // reset state
    #12;
    chk("rst_play_data", play_data, 32'h0);
    chk("rst_play_valid", play_valid, 1'b0);
    chk("rst_pos", pos, 25'd0);
    chk("rst_flags", {overrun, rd_timeout}, 2'b00);
    chk("rst_bus", {sbus.chipselect, sbus.read_n, sbus.write_n, sbus.byteenable_n, sbus.address}, {1'b0, 1'b1, 1'b1, 4'hF, 25'h0});
    @(negedge clk); rst_n = 1'b1;

    // vector table: playback walk with wrap, overdub saturation, rec-only
    for (int i = 0; i < 11; i++) begin
      force_en  = vecs[i].fen;
      force_val = vecs[i].fval;
      if (vecs[i].play) begin
        exp_rd_q.push_back(vecs[i].addr);
        exp_play_q.push_back(vecs[i].exp_play);
      end
      if (vecs[i].rec) exp_wr_q.push_back({vecs[i].addr, vecs[i].exp_wdata});
      tick(vecs[i].play, vecs[i].rec, vecs[i].rdat);
      idle(10);
      chk($sformatf("vec%0d_pos", i), pos, vecs[i].exp_pos);
    end
    force_en = 1'b0;

    // waitrequest held 5 cycles on both read and write
    wait_n = 5; rd0 = rd_acc; wr0 = wr_acc;
    exp_rd_q.push_back(25'h103);
    exp_play_q.push_back(32'h1A3);
    exp_wr_q.push_back({25'h103, 32'h0000_01A4});
    tick(1'b1, 1'b1, 32'h0000_0001);
    idle(30);
    chk("wait_rd_count", rd_acc - rd0, 1);
    chk("wait_wr_count", wr_acc - wr0, 1);
    chk("wait_pos", pos, 25'd0);
    wait_n = 0;

    // read timeout, late data swallowed, next read captured
    loop_base = 25'h200; loop_len = 25'd8;
    pulse_clear();
    drop_rd = 1'b1;
    exp_rd_q.push_back(25'h200);
    exp_play_q.push_back(32'h0);
    tick(1'b1, 1'b0, 32'h0);
    idle(25);
    chk("to_flag", rd_timeout, 1'b1);
    chk("to_play_data", play_data, 32'h0);
    chk("to_pos", pos, 25'd1);
    drop_rd = 1'b0;
    inj_data = 32'hDEAD_BEEF; inj_v = 1'b1;
    idle(1);
    inj_v = 1'b0;
    idle(3);
    chk("late_ignored", play_data, 32'h0);
    exp_rd_q.push_back(25'h201);
    exp_play_q.push_back(32'h2A1);
    tick(1'b1, 1'b0, 32'h0);
    idle(10);
    chk("after_to_capture", play_data, 32'h2A1);
    chk("to_sticky", rd_timeout, 1'b1);

    // boundaries: zero length, shrinking length, overrun, clear mid-write
    pulse_clear();
    chk("clear_flags", {overrun, rd_timeout}, 2'b00);
    chk("clear_pos", pos, 25'd0);
    loop_base = 25'h300; loop_len = 25'd0;
    for (int k = 0; k < 2; k++) begin
      exp_rd_q.push_back(25'h300);
      exp_play_q.push_back(32'h3A0);
      tick(1'b1, 1'b0, 32'h0);
      idle(10);
      chk("len0_pos", pos, 25'd0);
    end
    loop_len = 25'd8;
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      idle(6);
    end
    chk("pos5", pos, 25'd5);
    loop_len = 25'd2;
    tick(1'b0, 1'b0, 32'h0);
    idle(6);
    chk("shrink_pos", pos, 25'd0);
    wait_n = 5;
    exp_rd_q.push_back(25'h300);
    exp_play_q.push_back(32'h3A0);
    tick(1'b1, 1'b0, 32'h0);
    idle(2);
    tick(1'b1, 1'b0, 32'h0);
    idle(25);
    chk("overrun", overrun, 1'b1);
    chk("overrun_pos", pos, 25'd1);
    exp_wr_q.push_back({25'h301, 32'hCAFE_0001});
    tick(1'b0, 1'b1, 32'hCAFE_0001);
    idle(2);
    pulse_clear();
    idle(20);
    chk("clr_mid_pos", pos, 25'd0);
    chk("clr_mid_flags", {overrun, rd_timeout}, 2'b00);

    // async reset in RD_REQ
    exp_rd_q.push_back(25'h300);
    exp_play_q.push_back(32'h3A0);
    tick(1'b1, 1'b0, 32'h0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bus", {sbus.chipselect, sbus.read_n, sbus.write_n, sbus.byteenable_n}, {1'b0, 1'b1, 1'b1, 4'hF});
    chk("arst_pos", pos, 25'd0);
    exp_rd_q.delete(); exp_play_q.delete();
    wait_n = 0;
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    exp_rd_q.push_back(25'h300);
    exp_play_q.push_back(32'h3A0);
    tick(1'b1, 1'b0, 32'h0);
    idle(10);
    chk("restart_play", play_data, 32'h3A0);
    chk("restart_pos", pos, 25'd1);

    chk("sb_rd_empty", exp_rd_q.size(), 0);
    chk("sb_wr_empty", exp_wr_q.size(), 0);
    chk("sb_play_empty", exp_play_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
